// File: rtl/mux_pkg.sv
// Shared definitions for the scanning channel multiplexer.
//   state_t      : sequencer state encoding
//   MODE_MANUAL  : mode input value selecting direct channel select
//   MODE_SCAN    : mode input value selecting round-robin scanning
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MANUAL  = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bus bundle between the channel sources / consumer and the sequencer.
//   din       : flattened channel data, channel k = din[k*WIDTH +: WIDTH]
//   mode      : manual (0) or scan (1)
//   sel_in    : manual channel select
//   en_mask   : per-channel enable
//   dwell     : settle cycles before a scan capture
//   out_ready : consumer ready
//   y/y_sel   : registered sample and the channel it came from
//   y_valid   : y/y_sel valid
//   scan_wrap : one-cycle pulse when the scan wraps around
// master drives the request side, slave is the sequencer.
interface mux_scan_sequencer_if #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 8,
  parameter int DWELL_W  = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS-1:0]       en_mask;
  logic [DWELL_W-1:0]        dwell;
  logic                      out_ready;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          y_sel;
  logic                      y_valid;
  logic                      scan_wrap;

  modport master (
    output din, mode, sel_in, en_mask, dwell, out_ready,
    input  y, y_sel, y_valid, scan_wrap
  );

  modport slave (
    input  din, mode, sel_in, en_mask, dwell, out_ready,
    output y, y_sel, y_valid, scan_wrap
  );
endinterface

// File: rtl/mux_next_enabled.sv
// Circular priority search: returns the first set mask bit strictly above
// cur (wrapping through 0). With cur = CHANNELS-1 this yields the lowest
// enabled channel.
//   mask  : channel enables
//   cur   : search start (excluded unless it is the only set bit)
//   nxt   : next enabled index (cur when nothing is enabled)
//   wrap  : nxt <= cur, i.e. the search passed the top of the range
//   found : at least one mask bit set
module mux_next_enabled #(
  parameter int CHANNELS = 8,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap,
  output logic                found
);

  logic [SEL_W-1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  // Offset CHANNELS lands back on cur itself (single-channel case).
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    k     = '0;
    for (int off = CHANNELS; off >= 1; off--) begin
      k = SEL_W'((int'(cur) + off) % CHANNELS);
      if (mask[k]) begin
        nxt   = k;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Registered N-channel multiplexer with manual select and a scanning mode.
// Manual: y follows din[sel_in] with one cycle latency, valid when the
// selected channel is in range and enabled.
// Scan: visits enabled channels in ascending circular order, waits dwell
// cycles on each, captures once and holds the sample on a valid/ready
// handshake until the consumer takes it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mux_scan_sequencer_if slave (data, controls, outputs)
module mux_scan_sequencer #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 8,
  parameter int DWELL_W  = 8
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_sequencer_if.slave  bus
);
  import mux_pkg::*;

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;

  state_t           state, state_n;
  logic [SEL_W-1:0] cur_sel, cur_sel_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] y_q, y_n;
  logic [SEL_W-1:0] y_sel_q, y_sel_n;
  logic             y_valid_q, y_valid_n;
  logic             scan_wrap_q, scan_wrap_n;

  logic [SEL_W-1:0] search_from, nxt;
  logic             nxt_wrap, any_en;
  logic             man_ok, abort;
  logic [WIDTH-1:0] man_data;

  assign ch_data = bus.din;

  // One search unit: from the current channel while presenting (next hop),
  // otherwise from the top index, which yields the lowest enabled channel.
  assign search_from = (state == PRESENT) ? cur_sel : LAST_CH;

  mux_next_enabled #(.CHANNELS(CHANNELS)) u_next (
    .mask  (bus.en_mask),
    .cur   (search_from),
    .nxt   (nxt),
    .wrap  (nxt_wrap),
    .found (any_en)
  );

  // Out-of-range selects (non power-of-two CHANNELS) give a clean zero.
  assign man_ok   = (int'(bus.sel_in) < CHANNELS) && bus.en_mask[bus.sel_in];
  assign man_data = man_ok ? ch_data[bus.sel_in] : '0;

  // Scan is dropped on a mode change or when nothing is left enabled.
  assign abort = (bus.mode == MODE_MANUAL) || !any_en;

  always_comb begin
    state_n     = state;
    cur_sel_n   = cur_sel;
    cnt_n       = cnt;
    y_n         = y_q;
    y_sel_n     = y_sel_q;
    y_valid_n   = y_valid_q;
    scan_wrap_n = 1'b0;
    case (state)
      IDLE: begin
        y_valid_n = 1'b0;
        if (bus.mode == MODE_MANUAL) begin
          state_n   = MANUAL;
          y_n       = man_data;
          y_sel_n   = bus.sel_in;
          y_valid_n = man_ok;
        end else if (any_en) begin
          state_n   = SETTLE;
          cur_sel_n = nxt;
          cnt_n     = bus.dwell;
        end
      end
      MANUAL: begin
        if (bus.mode == MODE_SCAN) begin
          state_n   = IDLE;
          y_valid_n = 1'b0;
        end else begin
          y_n       = man_data;
          y_sel_n   = bus.sel_in;
          y_valid_n = man_ok;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n   = IDLE;
          y_valid_n = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          // Capture even if this channel was disabled during the dwell.
          state_n   = PRESENT;
          y_n       = ch_data[cur_sel];
          y_sel_n   = cur_sel;
          y_valid_n = 1'b1;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_n   = IDLE;
          y_valid_n = 1'b0;
        end else if (y_valid_q && bus.out_ready) begin
          state_n     = SETTLE;
          y_valid_n   = 1'b0;
          cur_sel_n   = nxt;
          cnt_n       = bus.dwell;
          scan_wrap_n = nxt_wrap;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_sel     <= '0;
      cnt         <= '0;
      y_q         <= '0;
      y_sel_q     <= '0;
      y_valid_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state       <= state_n;
      cur_sel     <= cur_sel_n;
      cnt         <= cnt_n;
      y_q         <= y_n;
      y_sel_q     <= y_sel_n;
      y_valid_q   <= y_valid_n;
      scan_wrap_q <= scan_wrap_n;
    end
  end

  assign bus.y         = y_q;
  assign bus.y_sel     = y_sel_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule
